// File: rtl/tiny_eth_rx_framer.sv
// Serial Ethernet receive framer: SFD hunt, LSB-first deserialisation, FIFO-buffered byte stream.
// Optional CRC-32 frame check is compiled in when TINY_ETH_RX_CRC_EN is defined.
module tiny_eth_rx_framer #(
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_BYTES  = 1518
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       d,
  input  logic       d_en,
  input  logic       crs,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       o_ready,
  output logic       o_last,
  output logic       o_err,
  output logic       o_overflow,
  output logic [2:0] dbg_state
);

  localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = $clog2(MAX_BYTES + 1);

  localparam logic [2:0] S_WAIT = 3'd0;
  localparam logic [2:0] S_IDLE = 3'd1;
  localparam logic [2:0] S_HUNT = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_DROP = 3'd4;

  logic [2:0]    state, state_n;
  logic [7:0]    shreg;
  logic [7:0]    shnext;
  logic [2:0]    bitcnt;
  logic [BW-1:0] bytecnt;
  logic [7:0]    pend_data;
  logic          pend_valid;
  logic          ovf_q;

  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;

  logic       acc, sfd_hit, byte_done, at_max, crc_bad;
  logic       push, full, pop, wr, overflow;
  logic [9:0] push_word;

  assign acc       = d_en & crs;
  assign shnext    = {d, shreg[7:1]};
  assign sfd_hit   = acc && (shnext == 8'hD5);
  assign byte_done = (state == S_DATA) && acc && (bitcnt == 3'd7);
  assign at_max    = (bytecnt == BW'(MAX_BYTES));

`ifdef TINY_ETH_RX_CRC_EN
  logic [31:0] crc;
  logic [31:0] crc_step;
  assign crc_step = {1'b0, crc[31:1]} ^ ((crc[0] ^ d) ? 32'hEDB88320 : 32'h0);
  assign crc_bad  = (crc != 32'hDEBB20E3);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      crc <= 32'hFFFFFFFF;
    end else if ((state == S_IDLE || state == S_HUNT) && sfd_hit) begin
      crc <= 32'hFFFFFFFF;
    end else if (state == S_DATA && acc) begin
      crc <= crc_step;
    end
  end
`else
  assign crc_bad = 1'b0;
`endif

  // Output stream: a beat transfers on any cycle where o_valid && o_ready are both
  // high; while o_ready is low the beat (data/last/err) is held unchanged.
  assign full    = (count == CW'(FIFO_DEPTH));
  assign o_valid = (count != '0);
  assign pop     = o_valid && o_ready;
  assign {o_err, o_last, o_data} = mem[rptr];
  assign o_overflow = ovf_q;
  assign dbg_state  = state;

  always_comb begin
    state_n   = state;
    push      = 1'b0;
    push_word = '0;
    case (state)
      S_WAIT: if (!crs) state_n = S_IDLE;
      S_IDLE: if (crs) state_n = sfd_hit ? S_DATA : S_HUNT;
      S_HUNT: begin
        if (!crs) state_n = S_IDLE;
        else if (sfd_hit) state_n = S_DATA;
      end
      S_DATA: begin
        if (!crs) begin
          state_n   = S_IDLE;
          push      = pend_valid;
          push_word = {(bitcnt != 3'd0) | crc_bad, 1'b1, pend_data};
        end else if (byte_done) begin
          push = pend_valid;
          if (at_max) begin
            state_n   = S_WAIT;
            push_word = {2'b11, pend_data};
          end else begin
            push_word = {2'b00, pend_data};
          end
        end
      end
      S_DROP: state_n = S_WAIT;
      default: state_n = S_WAIT;
    endcase
    // A pop in the same cycle frees a slot, so only a full FIFO without a pop overflows.
    overflow = push && full && !pop;
    wr       = push && !overflow;
    if (overflow) state_n = S_DROP;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr) begin
        mem[wptr] <= push_word;
        wptr      <= wptr + AW'(1);
      end
      if (pop) rptr <= rptr + AW'(1);
      count <= count + CW'(wr) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_WAIT;
      shreg      <= '0;
      bitcnt     <= '0;
      bytecnt    <= '0;
      pend_data  <= '0;
      pend_valid <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state <= state_n;
      ovf_q <= overflow;

      // Clearing between frames keeps stale bits from forming a false SFD.
      if (!crs) shreg <= '0;
      else if (acc && (state == S_IDLE || state == S_HUNT || state == S_DATA)) shreg <= shnext;

      if ((state == S_IDLE || state == S_HUNT) && sfd_hit) begin
        bitcnt     <= '0;
        bytecnt    <= '0;
        pend_valid <= 1'b0;
      end else if (overflow) begin
        pend_valid <= 1'b0;
      end else if (state == S_DATA) begin
        if (!crs) begin
          pend_valid <= 1'b0;
        end else if (acc) begin
          bitcnt <= bitcnt + 3'd1;
          if (byte_done) begin
            if (at_max) begin
              pend_valid <= 1'b0;
            end else begin
              pend_data  <= shnext;
              pend_valid <= 1'b1;
              bytecnt    <= bytecnt + BW'(1);
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_tiny_eth_rx_framer.sv
// Directed bench for tiny_eth_rx_framer: two instances (default MAX_BYTES and MAX_BYTES=4)
// share stimulus; beats are collected by a negedge monitor and compared against expected queues.
module tb_tiny_eth_rx_framer;
  localparam int FD = 8;
`ifdef TINY_ETH_RX_CRC_EN
  localparam logic CRC_ON = 1'b1;
`else
  localparam logic CRC_ON = 1'b0;
`endif

  logic       clk, rst, d, d_en, crs, o_ready;
  logic [7:0] a_data, b_data;
  logic       a_valid, a_last, a_err, a_ovf;
  logic       b_valid, b_last, b_err, b_ovf;
  logic [2:0] a_dbg, b_dbg;

  int errors = 0;
  int checks = 0;
  int ovf_a  = 0;
  logic [9:0] exp_q[$];
  logic [9:0] got_a[$];
  logic [9:0] got_b[$];

  tiny_eth_rx_framer #(.FIFO_DEPTH(FD), .MAX_BYTES(1518)) dut_a (
    .clk(clk), .rst(rst), .d(d), .d_en(d_en), .crs(crs),
    .o_data(a_data), .o_valid(a_valid), .o_ready(o_ready), .o_last(a_last),
    .o_err(a_err), .o_overflow(a_ovf), .dbg_state(a_dbg)
  );

  tiny_eth_rx_framer #(.FIFO_DEPTH(FD), .MAX_BYTES(4)) dut_b (
    .clk(clk), .rst(rst), .d(d), .d_en(d_en), .crs(crs),
    .o_data(b_data), .o_valid(b_valid), .o_ready(o_ready), .o_last(b_last),
    .o_err(b_err), .o_overflow(b_ovf), .dbg_state(b_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // monitor: inputs change just after posedge, so a negedge sample predicts the next transfer
  always @(negedge clk) begin
    if (rst) begin
      if (a_valid && o_ready) got_a.push_back({a_err, a_last, a_data});
      if (b_valid && o_ready) got_b.push_back({b_err, b_last, b_data});
      if (a_ovf) ovf_a++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_frame(input string tag, input logic [9:0] g[$]);
    check({tag, " count"}, 32'(g.size()), 32'(exp_q.size()));
    foreach (exp_q[i])
      check($sformatf("%s beat%0d", tag, i), (i < g.size()) ? 32'(g[i]) : 32'hFFFFFFFF, 32'(exp_q[i]));
    exp_q.delete();
  endtask

  // driver tasks
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    @(posedge clk);
    #1;
    d = b; d_en = 1'b1; crs = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
  endtask

  task automatic preamble();
    for (int i = 0; i < 7; i++) send_byte(8'h55);
    send_byte(8'hD5);
  endtask

  task automatic end_frame(input int n);
    @(posedge clk);
    #1;
    d = 1'b0; d_en = 1'b0; crs = 1'b0;
    cycles(n);
  endtask

  task automatic push_exp(input logic [7:0] data, input logic last, input logic err);
    exp_q.push_back({err, last, data});
  endtask

`ifdef TINY_ETH_RX_CRC_EN
  function automatic logic [31:0] crc32(input logic [7:0] fr[60], input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < 8; j++)
        c = {1'b0, c[31:1]} ^ ((c[0] ^ fr[i][j]) ? 32'hEDB88320 : 32'h0);
    return c;
  endfunction
`endif

  initial begin
    rst = 1'b0; d = 1'b0; d_en = 1'b0; crs = 1'b0; o_ready = 1'b1;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst o_valid", 32'(a_valid), 32'd0);
    check("rst o_data", 32'(a_data), 32'd0);
    check("rst o_last", 32'(a_last), 32'd0);
    check("rst o_err", 32'(a_err), 32'd0);
    check("rst o_overflow", 32'(a_ovf), 32'd0);
    check("rst state", 32'(a_dbg), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    // 1: reset in the middle of a carrier, no sync until crs cycles low
    for (int i = 0; i < 3; i++) send_byte(8'h55);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("t1 midrst state", 32'(a_dbg), 32'd0);
    check("t1 midrst valid", 32'(a_valid), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    got_a.delete();
    preamble();
    send_byte(8'h3C);
    send_byte(8'h3C);
    @(posedge clk);
    #1 d_en = 1'b0;
    cycles(5);
    check("t1 no sync beats", 32'(got_a.size()), 32'd0);
    check("t1 wait state", 32'(a_dbg), 32'd0);
    end_frame(3);
    preamble();
    send_byte(8'h3C);
    end_frame(6);
    push_exp(8'h3C, 1'b1, CRC_ON);
    check_frame("t1", got_a);
    got_a.delete();

    // 2: clean three-byte frame, crs drops on a byte boundary
    preamble();
    send_byte(8'h01);
    send_byte(8'h02);
    @(negedge clk);
    check("t2 pending not visible", 32'(a_valid), 32'd0);
    send_byte(8'h03);
    end_frame(6);
    push_exp(8'h01, 1'b0, 1'b0);
    push_exp(8'h02, 1'b0, 1'b0);
    push_exp(8'h03, 1'b1, CRC_ON);
    check_frame("t2", got_a);
    got_a.delete();

    // 3: three trailing bits -> alignment error on last beat
    preamble();
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    end_frame(6);
    push_exp(8'h01, 1'b0, 1'b0);
    push_exp(8'h02, 1'b0, 1'b0);
    push_exp(8'h03, 1'b1, 1'b1);
    check_frame("t3", got_a);
    got_a.delete();

    // 4: stalled consumer, FD+2 bytes -> FIFO fills, one overflow pulse, no last beat
    o_ready = 1'b0;
    ovf_a   = 0;
    preamble();
    for (int i = 0; i < FD + 2; i++) send_byte(8'h10 + 8'(i));
    end_frame(4);
    @(negedge clk);
    check("t4 held valid", 32'(a_valid), 32'd1);
    check("t4 held data", 32'(a_data), 32'h10);
    check("t4 held last", 32'(a_last), 32'd0);
    cycles(5);
    @(negedge clk);
    check("t4 still held data", 32'(a_data), 32'h10);
    check("t4 overflow pulses", 32'(ovf_a), 32'd1);
    check("t4 no transfers", 32'(got_a.size()), 32'd0);
    @(posedge clk);
    #1 o_ready = 1'b1;
    cycles(FD + 4);
    for (int i = 0; i < FD; i++) push_exp(8'h10 + 8'(i), 1'b0, 1'b0);
    check_frame("t4", got_a);
    got_a.delete();

`ifdef TINY_ETH_RX_CRC_EN
    // 5: 60-byte frame with FCS, then the same with one payload bit flipped
    begin
      logic [7:0]  fr[60];
      logic [31:0] fcs;
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 56; i++) fr[i] = 8'(i * 7 + 3);
        fcs = ~crc32(fr, 56);
        for (int i = 0; i < 4; i++) fr[56 + i] = fcs[8*i +: 8];
        if (k == 1) fr[10] = fr[10] ^ 8'h04;
        got_a.delete();
        preamble();
        for (int i = 0; i < 60; i++) send_byte(fr[i]);
        end_frame(8);
        check($sformatf("t5.%0d count", k), 32'(got_a.size()), 32'd60);
        check($sformatf("t5.%0d last beat", k), (got_a.size() == 60) ? 32'(got_a[59]) : 32'hFFFFFFFF,
              32'({(k == 1), 1'b1, fr[59]}));
      end
      got_a.delete();
    end
`endif

    // 6: MAX_BYTES=4 instance, 6-byte frame -> truncated with err, then recovery
    @(posedge clk);
    #1 rst = 1'b0;
    cycles(3);
    rst = 1'b1;
    got_a.delete();
    got_b.delete();
    preamble();
    for (int i = 0; i < 6; i++) send_byte(8'hA1 + 8'(i));
    end_frame(8);
    push_exp(8'hA1, 1'b0, 1'b0);
    push_exp(8'hA2, 1'b0, 1'b0);
    push_exp(8'hA3, 1'b0, 1'b0);
    push_exp(8'hA4, 1'b1, 1'b1);
    check_frame("t6", got_b);
    check("t6 idle after crs low", 32'(b_dbg), 32'd1);
    got_b.delete();
    preamble();
    send_byte(8'h77);
    end_frame(6);
    push_exp(8'h77, 1'b1, CRC_ON);
    check_frame("t6 recover", got_b);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
